// File: rtl/sram_multibeat_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_multibeat_controller_pkg
//  Description : Shared types and constants for the multi-beat SRAM
//                controller. Holds the FSM state encoding, the latched
//                operation type and the default CPU base address.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package sram_multibeat_controller_pkg;

    // CPU-side byte address width
    localparam int c_cpu_addr_w = 32;

    // CPU byte address that maps to SRAM word 0 unless overridden
    localparam logic [c_cpu_addr_w-1:0] c_default_base_addr = 32'd1024;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

endpackage : sram_multibeat_controller_pkg
`default_nettype wire

// File: rtl/sram_multibeat_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : sram_multibeat_controller_if
//  Description : CPU (MEM stage) request bus of the SRAM controller.
//  Ports       : master - CPU side: drives read_en, write_en, address,
//                         write_data; receives read_data, ready, err
//                slave  - controller side: the reverse directions
//  Revision    : 1.0 - initial release
// ============================================================================
interface sram_multibeat_controller_if
    import sram_multibeat_controller_pkg::*;
#(
    parameter int DATA_W = 32
);
    logic                     read_en;
    logic                     write_en;
    logic [c_cpu_addr_w-1:0]  address;
    logic [DATA_W-1:0]        write_data;
    logic [DATA_W-1:0]        read_data;
    logic                     ready;
    logic                     err;

    modport master (
        output read_en, write_en, address, write_data,
        input  read_data, ready, err
    );

    modport slave (
        input  read_en, write_en, address, write_data,
        output read_data, ready, err
    );

endinterface : sram_multibeat_controller_if
`default_nettype wire

// File: rtl/sram_multibeat_controller_beat_timer.sv
`default_nettype none
// ============================================================================
//  Module      : sram_beat_timer
//  Description : Wait-cycle and beat counters for one multi-beat access.
//                The wait counter runs 0..WAIT_CYCLES-1 inside each beat;
//                the beat counter advances when a beat's last wait cycle
//                completes.
//  Ports       : clk, rst_n     - clock, async active-low reset
//                i_clear        - zero both counters
//                i_run          - advance counters this cycle
//                o_beat         - current beat index
//                o_last_wait    - current cycle is the last of the beat
//                o_last_beat    - current beat is the final one
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_beat_timer
    import sram_multibeat_controller_pkg::*;
#(
    parameter int WAIT_CYCLES = 3,
    parameter int BEATS       = 2,
    parameter int BEAT_W      = $clog2(BEATS) + 1
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              i_clear,
    input  wire logic              i_run,
    output logic [BEAT_W-1:0]      o_beat,
    output logic                   o_last_wait,
    output logic                   o_last_beat
);

    localparam int                c_wait_w    = $clog2(WAIT_CYCLES);
    localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(WAIT_CYCLES - 1);
    localparam logic [BEAT_W-1:0] c_beat_last = BEAT_W'(BEATS - 1);

    logic [c_wait_w-1:0] r_wait;
    logic [BEAT_W-1:0]   r_beat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait <= '0;
            r_beat <= '0;
        end else if (i_clear) begin
            r_wait <= '0;
            r_beat <= '0;
        end else if (i_run) begin
            if (r_wait == c_wait_last) begin
                r_wait <= '0;
                r_beat <= r_beat + BEAT_W'(1);
            end else begin
                r_wait <= r_wait + c_wait_w'(1);
            end
        end
    end

    assign o_beat      = r_beat;
    assign o_last_wait = (r_wait == c_wait_last);
    assign o_last_beat = (r_beat == c_beat_last);

endmodule : sram_beat_timer
`default_nettype wire

// File: rtl/sram_multibeat_controller.sv
`default_nettype none
// ============================================================================
//  Module      : sram_multibeat_controller
//  Description : Bridges the MEM stage to an external asynchronous SRAM.
//                A DATA_W-bit CPU word is moved as DATA_W/SRAM_DQ_W beats of
//                WAIT_CYCLES cycles each. Out-of-range requests complete in
//                one cycle with err set and no SRAM strobe. ready stalls the
//                pipeline until the access finishes.
//  Ports       : clk, rst_n  - clock, async active-low reset
//                cpu         - CPU request bus (slave modport):
//                              read_en, write_en, address, write_data in;
//                              read_data, ready, err out
//                SRAM_dq     - bidirectional SRAM data
//                SRAM_addr   - SRAM word address
//                SRAM_we_n   - SRAM write enable, active low
//                SRAM_oe_n   - SRAM output enable, active low
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_multibeat_controller
    import sram_multibeat_controller_pkg::*;
#(
    parameter int                      DATA_W      = 32,
    parameter int                      SRAM_DQ_W   = 16,
    parameter int                      SRAM_ADDR_W = 18,
    parameter int                      WAIT_CYCLES = 3,
    parameter logic [c_cpu_addr_w-1:0] BASE_ADDR   = c_default_base_addr
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    sram_multibeat_controller_if.slave   cpu,
    inout  wire logic [SRAM_DQ_W-1:0]    SRAM_dq,
    output logic [SRAM_ADDR_W-1:0]       SRAM_addr,
    output logic                         SRAM_we_n,
    output logic                         SRAM_oe_n
);

    localparam int c_beats      = DATA_W / SRAM_DQ_W;
    localparam int c_beat_w     = $clog2(c_beats) + 1;
    localparam int c_byte_shift = $clog2(DATA_W / 8);
    // Bytes of CPU address space the SRAM can back; 64-bit so large
    // SRAM_ADDR_W values cannot overflow the comparison.
    localparam logic [63:0] c_range_bytes =
        ((64'd1 << SRAM_ADDR_W) / 64'(c_beats)) * 64'(DATA_W / 8);

    state_t                    r_state;
    state_t                    w_next_state;
    op_t                       r_op;
    logic [c_cpu_addr_w-1:0]   r_addr;
    logic [DATA_W-1:0]         r_wdata;
    logic [DATA_W-1:0]         r_read_data;
    logic                      r_err;

    logic                      w_req;
    logic [c_cpu_addr_w-1:0]   w_req_off;
    logic                      w_req_oor;
    logic                      w_ready;
    logic                      w_in_access;
    logic                      w_is_write;
    logic                      w_dq_oe;
    logic [SRAM_DQ_W-1:0]      w_wr_slice;
    logic [c_cpu_addr_w-1:0]   w_word_base;

    logic [c_beat_w-1:0]       w_beat;
    logic                      w_last_wait;
    logic                      w_last_beat;

    // ------------------------------------------------------------------
    // Request decode; the range check runs on the incoming address so an
    // out-of-range request can go straight to DONE.
    // ------------------------------------------------------------------
    assign w_req     = cpu.read_en | cpu.write_en;
    assign w_req_off = cpu.address - BASE_ADDR;
    assign w_req_oor = (cpu.address < BASE_ADDR) ||
                       ({32'd0, w_req_off} >= c_range_bytes);

    // ------------------------------------------------------------------
    // Beat/wait timing
    // ------------------------------------------------------------------
    sram_beat_timer #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .BEATS       (c_beats),
        .BEAT_W      (c_beat_w)
    ) u_beat_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (r_state == ST_IDLE),
        .i_run       (w_in_access),
        .o_beat      (w_beat),
        .o_last_wait (w_last_wait),
        .o_last_beat (w_last_beat)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and ready
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = !w_req;
                if (w_req) begin
                    w_next_state = w_req_oor ? ST_DONE : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (w_last_wait && w_last_beat) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_ready      = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture and error flag. read_en wins when both are high.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_op    <= OP_READ;
            r_err   <= 1'b0;
        end else if (r_state == ST_IDLE && w_req) begin
            r_addr  <= cpu.address;
            r_wdata <= cpu.write_data;
            r_op    <= cpu.read_en ? OP_READ : OP_WRITE;
            r_err   <= w_req_oor;
        end else if (r_state == ST_DONE) begin
            r_err   <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Read capture: each beat's slice is taken on its last wait cycle,
    // when the SRAM output has had the longest time to settle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_read_data <= '0;
        end else if (w_in_access && !w_is_write && w_last_wait) begin
            for (int b = 0; b < c_beats; b++) begin
                if (w_beat == c_beat_w'(b)) begin
                    r_read_data[b*SRAM_DQ_W +: SRAM_DQ_W] <= SRAM_dq;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // SRAM pin drive. Strobes and the dq enable decode straight from the
    // state register so an asynchronous reset releases the bus at once.
    // ------------------------------------------------------------------
    assign w_in_access = (r_state == ST_ACCESS);
    assign w_is_write  = (r_op == OP_WRITE);
    assign w_dq_oe     = w_in_access && w_is_write;

    always_comb begin
        w_wr_slice = '0;
        for (int b = 0; b < c_beats; b++) begin
            if (w_beat == c_beat_w'(b)) begin
                w_wr_slice = r_wdata[b*SRAM_DQ_W +: SRAM_DQ_W];
            end
        end
    end

    // we_n rises on the last cycle of each beat so address and data are
    // held stable across the write-enable release edge.
    assign SRAM_we_n = !(w_in_access && w_is_write && !w_last_wait);
    assign SRAM_oe_n = !(w_in_access && !w_is_write);
    assign SRAM_dq   = w_dq_oe ? w_wr_slice : {SRAM_DQ_W{1'bz}};

    // Sub-word address bits are dropped; each CPU word occupies c_beats
    // consecutive SRAM words.
    assign w_word_base = (r_addr - BASE_ADDR) >> c_byte_shift;
    assign SRAM_addr   = w_in_access
                       ? SRAM_ADDR_W'(w_word_base * 32'(c_beats) + 32'(w_beat))
                       : '0;

    // ------------------------------------------------------------------
    // CPU bus outputs
    // ------------------------------------------------------------------
    assign cpu.read_data = r_read_data;
    assign cpu.ready     = w_ready;
    assign cpu.err       = r_err;

endmodule : sram_multibeat_controller
`default_nettype wire

// File: tb/tb_sram_multibeat_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_multibeat_controller
//  Description : Self-checking bench for sram_multibeat_controller. Drives
//                directed requests into a default-parameter instance and a
//                DATA_W=64 / WAIT_CYCLES=2 instance, each with its own SRAM
//                model. Expected responses are queued at issue time and
//                compared by a monitor when the request completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_multibeat_controller;

    typedef struct {
        bit          is_rd;
        logic [31:0] data;
        bit          err;
        int          lat;
        int          we_lo;
        int          oe_lo;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        mon_en;
    int          n_checks;
    int          n_fail;
    exp_t        sb[$];

    sram_multibeat_controller_if #(.DATA_W(32)) bus  ();
    sram_multibeat_controller_if #(.DATA_W(64)) bus2 ();

    wire  [15:0] dq1;
    wire  [15:0] dq2;
    logic [17:0] addr1;
    logic [17:0] addr2;
    logic        we1_n;
    logic        oe1_n;
    logic        we2_n;
    logic        oe2_n;

    logic [15:0] mem1 [0:262143];
    logic [15:0] mem2 [0:262143];

    // Undriven data bus floats high, so any read of 16'hFFFF outside a
    // read phase means nobody is driving it.
    pullup (dq1);
    pullup (dq2);

    assign dq1 = !oe1_n ? mem1[addr1] : 16'hzzzz;
    assign dq2 = !oe2_n ? mem2[addr2] : 16'hzzzz;

    sram_multibeat_controller dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu       (bus),
        .SRAM_dq   (dq1),
        .SRAM_addr (addr1),
        .SRAM_we_n (we1_n),
        .SRAM_oe_n (oe1_n)
    );

    sram_multibeat_controller #(
        .DATA_W      (64),
        .WAIT_CYCLES (2)
    ) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu       (bus2),
        .SRAM_dq   (dq2),
        .SRAM_addr (addr2),
        .SRAM_we_n (we2_n),
        .SRAM_oe_n (oe2_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM models: store while write enable is low (data is stable for
    // the whole beat).
    initial begin
        forever begin
            @(negedge clk);
            if (!we1_n) mem1[addr1] = dq1;
            if (!we2_n) mem2[addr2] = dq2;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(bit rd, logic [31:0] d, bit e, int lat, int we_lo, int oe_lo);
        exp_t x;
        x.is_rd = rd;
        x.data  = d;
        x.err   = e;
        x.lat   = lat;
        x.we_lo = we_lo;
        x.oe_lo = oe_lo;
        return x;
    endfunction

    // Monitor for the default instance: accumulates per-request latency and
    // strobe counts, and compares against the queued expectation on the
    // cycle the controller reports completion.
    initial begin
        int   lat;
        int   we_lo;
        int   oe_lo;
        int   dq_bad;
        logic req;
        logic is_wr;
        exp_t e;
        lat = 0; we_lo = 0; oe_lo = 0; dq_bad = 0;
        forever begin
            @(negedge clk);
            req   = bus.read_en | bus.write_en;
            is_wr = bus.write_en & ~bus.read_en;
            if (!mon_en || !req || !rst_n) begin
                lat = 0; we_lo = 0; oe_lo = 0; dq_bad = 0;
            end else begin
                if (!we1_n) we_lo++;
                if (!oe1_n) oe_lo++;
                if (!is_wr && oe1_n && dq1 !== 16'hFFFF) dq_bad++;
                if (!bus.ready) begin
                    lat++;
                end else begin
                    if (sb.size() == 0) begin
                        check("unexpected_completion", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("latency", lat, e.lat);
                        check("err", bus.err, e.err);
                        check("we_n_low_cycles", we_lo, e.we_lo);
                        check("oe_n_low_cycles", oe_lo, e.oe_lo);
                        if (e.is_rd) begin
                            check("read_data", bus.read_data, e.data);
                            check("dq_released_on_read", dq_bad, 0);
                        end
                    end
                    lat = 0; we_lo = 0; oe_lo = 0; dq_bad = 0;
                end
            end
        end
    end

    task automatic do_req(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input exp_t e);
        bit done;
        done = 1'b0;
        sb.push_back(e);
        bus.read_en    = rd;
        bus.write_en   = wr;
        bus.address    = a;
        bus.write_data = wd;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (bus.ready) done = 1'b1;
        end
        if (!done) begin
            check("request_timeout", 0, 1);
            if (sb.size() > 0) void'(sb.pop_front());
        end
        @(posedge clk);
        #1;
        bus.read_en  = 1'b0;
        bus.write_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_req2(input bit rd, input logic [31:0] a, input logic [63:0] wd,
                           output int lat, output int we_lo, output logic [63:0] rdata);
        bit done;
        done  = 1'b0;
        lat   = 0;
        we_lo = 0;
        rdata = '0;
        bus2.read_en    = rd;
        bus2.write_en   = !rd;
        bus2.address    = a;
        bus2.write_data = wd;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!we2_n) we_lo++;
            if (bus2.ready) begin
                done  = 1'b1;
                rdata = bus2.read_data;
            end else begin
                lat++;
            end
        end
        if (!done) check("request64_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus2.read_en  = 1'b0;
        bus2.write_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          lat2;
        int          we2;
        logic [63:0] rd2;
        n_checks = 0;
        n_fail   = 0;
        mon_en   = 1'b0;
        rst_n    = 1'b0;
        bus.read_en  = 1'b0; bus.write_en  = 1'b0; bus.address  = '0; bus.write_data  = '0;
        bus2.read_en = 1'b0; bus2.write_en = 1'b0; bus2.address = '0; bus2.write_data = '0;
        mem1[2] = 16'h1111; mem1[3] = 16'h2222;
        mem1[4] = 16'h3333; mem1[5] = 16'h4444;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", bus.ready, 1);
        check("reset_err", bus.err, 0);
        check("reset_read_data", bus.read_data, 0);
        check("reset_we_n", we1_n, 1);
        check("reset_oe_n", oe1_n, 1);
        check("reset_sram_addr", addr1, 0);
        check("reset_dq_released", dq1, 16'hFFFF);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Write then read back one word
        do_req(0, 1, 32'd1024, 32'hDEADBEEF, mk(0, 32'h0, 0, 7, 4, 0));
        check("mem_word0", mem1[0], 16'hBEEF);
        check("mem_word1", mem1[1], 16'hDEAD);
        do_req(1, 0, 32'd1024, 32'h0, mk(1, 32'hDEADBEEF, 0, 7, 0, 6));

        // Sub-word address bits are ignored
        do_req(1, 0, 32'd1027, 32'h0, mk(1, 32'hDEADBEEF, 0, 7, 0, 6));

        // Preloaded words 2,3
        do_req(1, 0, 32'd1028, 32'h0, mk(1, 32'h22221111, 0, 7, 0, 6));

        // Both enables high: read only, memory untouched
        do_req(1, 1, 32'd1032, 32'hAAAAAAAA, mk(1, 32'h44443333, 0, 7, 0, 6));
        check("both_en_mem_word4", mem1[4], 16'h3333);
        check("both_en_mem_word5", mem1[5], 16'h4444);

        // Out of range below and at the top boundary; read_data holds
        do_req(1, 0, 32'd1020, 32'h0, mk(1, 32'h44443333, 1, 1, 0, 0));
        do_req(1, 0, 32'd525312, 32'h0, mk(1, 32'h44443333, 1, 1, 0, 0));
        do_req(0, 1, 32'd1020, 32'h55555555, mk(0, 32'h0, 1, 1, 0, 0));
        check("err_cleared_after_done", bus.err, 0);

        // Last in-range word
        do_req(0, 1, 32'd525308, 32'h12345678, mk(0, 32'h0, 0, 7, 4, 0));
        check("mem_top_lo", mem1[262142], 16'h5678);
        check("mem_top_hi", mem1[262143], 16'h1234);
        do_req(1, 0, 32'd525308, 32'h0, mk(1, 32'h12345678, 0, 7, 0, 6));

        // Asynchronous reset during write beat 1
        mon_en = 1'b0;
        bus.write_en   = 1'b1;
        bus.address    = 32'd1024;
        bus.write_data = 32'hCAFEF00D;
        repeat (5) @(negedge clk);
        check("pre_reset_we_n", we1_n, 0);
        check("pre_reset_sram_addr", addr1, 1);
        check("pre_reset_dq", dq1, 16'hCAFE);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_we_n", we1_n, 1);
        check("midreset_oe_n", oe1_n, 1);
        check("midreset_dq_released", dq1, 16'hFFFF);
        check("midreset_sram_addr", addr1, 0);
        check("midreset_ready_with_req", bus.ready, 0);
        bus.write_en = 1'b0;
        #1;
        check("midreset_ready_no_req", bus.ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_ready", bus.ready, 1);
        check("post_reset_read_data", bus.read_data, 0);
        check("post_reset_err", bus.err, 0);
        check("post_reset_we_n", we1_n, 1);
        @(posedge clk);
        #1;

        // 64-bit word, 2-cycle beats
        do_req2(0, 32'd1032, 64'h0123456789ABCDEF, lat2, we2, rd2);
        check("w64_latency", lat2, 9);
        check("w64_we_n_low_cycles", we2, 4);
        check("w64_mem4", mem2[4], 16'hCDEF);
        check("w64_mem5", mem2[5], 16'h89AB);
        check("w64_mem6", mem2[6], 16'h4567);
        check("w64_mem7", mem2[7], 16'h0123);
        do_req2(1, 32'd1032, 64'h0, lat2, we2, rd2);
        check("r64_latency", lat2, 9);
        check("r64_we_n_low_cycles", we2, 0);
        check("r64_read_data", rd2, 64'h0123456789ABCDEF);

        check("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sram_multibeat_controller
`default_nettype wire
